rsa_uart_bridge: RTL
====================

// Module: rsa_uart_bridge
// PURPOSE
//  Avalon-MM master that feeds the RSA256 core from the RS232 UART and returns its results.
//  Receives key (n, then d) once after reset, then loops forever:
//    receive 32-byte ciphertext -> start core -> wait -> transmit 31-byte plaintext.
//  Drives the core's start/finished handshake from the requesting side.
//  Sits between the Qsys UART slave and the core in the Lab2 top level.
// PARAMETERS
//  RX_BASE      5'h0  UART rx data register address
//  TX_BASE      5'h4  UART tx data register address
//  STATUS_BASE  5'h8  UART status register address
//  RX_OK_BIT    7     status bit: rx byte available
//  TX_OK_BIT    6     status bit: tx ready
// PORTS
//  i_clk             in   1    clock
//  i_rst_n           in   1    asynchronous reset, active-low
//  avm_address       out  5    Avalon address
//  avm_read          out  1    Avalon read request
//  avm_readdata      in   32   Avalon read data; valid when avm_waitrequest=0
//  avm_write         out  1    Avalon write request
//  avm_writedata     out  32   Avalon write data
//  avm_waitrequest   in   1    Avalon stall
//  o_core_start      out  1    one-cycle start pulse to core
//  o_core_a          out  256  ciphertext
//  o_core_d          out  256  private exponent
//  o_core_n          out  256  modulus
//  i_core_result     in   256  core result, sampled when i_core_finished=1
//  i_core_finished   in   1    core done pulse
// BEHAVIOUR
//  Reset (i_rst_n=0, async, any cycle incl. mid-transfer):
//    - outputs: avm_read=0, avm_write=0, avm_address=STATUS_BASE, o_core_start=0, all 256b regs=0
//    - state S_GET_KEY, byte counter=0; key must be resent.
//  Top states and transitions:
//    S_GET_KEY -> S_GET_DATA  after 64 bytes
//    S_GET_DATA -> S_CALC     after 32 bytes
//    S_CALC -> S_SEND_DATA    on i_core_finished
//    S_SEND_DATA -> S_GET_DATA after 31 bytes
//  Byte phases (sub-state):
//    Receive: QRY_RX (read STATUS_BASE) then RD_RX (read RX_BASE).
//    Transmit: QRY_TX (read STATUS_BASE) then WR_TX (write TX_BASE).
//  Avalon rules:
//    - avm_read/avm_write and avm_address held stable while avm_waitrequest=1.
//    - A transfer completes in the cycle avm_waitrequest=0; request drops the next cycle.
//    - Never assert read and write together.
//    - Status poll with OK bit=0: issue a fresh QRY next cycle, no byte consumed.
//  Receive:
//    - Byte = avm_readdata[7:0], shifted into the LSB end of the target: reg <= {reg[247:0], byte}.
//    - Bytes 0-31 -> n, bytes 32-63 -> d (both MSB first), then 32 bytes -> a.
//    - Counter is 7b, cleared on each top-state change.
//  Calc:
//    - o_core_start high exactly the first cycle of S_CALC.
//    - o_core_a/d/n held constant until the next S_GET_DATA byte.
//    - On i_core_finished latch i_core_result into the tx shift reg.
//    - i_core_finished outside S_CALC is ignored.
//  Send:
//    - avm_writedata = {24'b0, tx[247:240]}; after each completed write tx <= tx << 8.
//    - Bits [255:248] are never sent; 31 bytes total, MSB first.
//  Key (n, d) is retained across blocks; only reset clears it.
//  No latency bound: progress is gated by UART status and the core.
// STRUCTURE
//  Shared package rsa_pkg:
//    - top-state enum
//    - byte-phase enum
//    - UART address/bit constants (defaults above)
//    - BLOCK_BYTES=32, OUT_BYTES=31
//  Sub-module: uart_byte_port (QRY/RD/WR Avalon sequencing and waitrequest handling).
//    - Handshake: req_rx/req_tx + tx_byte in; done + rx_byte out.
//  Parent holds the top FSM, counter and shift registers.
// TESTING
//  Avalon UART model with random waitrequest (0-3 cycles) and random RX_OK/TX_OK gaps; mock core.
//  1. Key+data: send n=0xBB (31 zero bytes, then 0xBB), d=0x17, a=0x58
//       -> o_core_n=0xBB, o_core_d=0x17, o_core_a=0x58; one o_core_start pulse.
//  2. Mock core returns 0x00_0102..1F after 10 cycles
//       -> TX bytes 0x01,0x02,...,0x1F in order; top byte 0x00 not sent; exactly 31 writes.
//  3. Second ciphertext block without resending key
//       -> n/d unchanged; new o_core_a; second start pulse; 31 more writes.
//  4. waitrequest held 5 cycles on an RD_RX
//       -> address/read stable throughout; byte captured once.
//  5. RX_OK=0 for 20 polls -> no byte shifted; counter unchanged.
//  6. Reset asserted mid-S_SEND_DATA (after byte 10)
//       -> immediate idle outputs; next 64 received bytes are treated as key.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA256 UART bridge: top-level and byte-phase
// state encodings, UART register map and block sizes.
package rsa_pkg;

    localparam logic [4:0] RX_BASE     = 5'h0;
    localparam logic [4:0] TX_BASE     = 5'h4;
    localparam logic [4:0] STATUS_BASE = 5'h8;
    localparam int         RX_OK_BIT   = 7;
    localparam int         TX_OK_BIT   = 6;

    localparam int BLOCK_BYTES = 32;
    localparam int OUT_BYTES   = 31;

    typedef enum logic [1:0] {
        S_GET_KEY,
        S_GET_DATA,
        S_CALC,
        S_SEND_DATA
    } top_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        QRY_RX,
        RD_RX,
        QRY_TX,
        WR_TX
    } byte_phase_t;

endpackage

// File: rtl/uart_byte_port.sv
// Moves one byte at a time over the Avalon UART: polls status until the relevant OK
// bit is set, then reads RX data or writes TX data, and pulses o_done on completion.
module uart_byte_port
    import rsa_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_rx,
    input  logic        i_req_tx,
    input  logic [7:0]  i_tx_byte,
    output logic        o_done,
    output logic [7:0]  o_rx_byte,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest
);

    byte_phase_t r_phase;
    byte_phase_t w_phase_next;
    logic        r_gap;
    logic        w_active;
    logic        w_xfer;
    logic        w_unused_rd;

    // r_gap forces the request low for one cycle after every completed transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= PH_IDLE;
            r_gap   <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_gap   <= w_xfer;
        end
    end

    assign w_active = (r_phase != PH_IDLE) && !r_gap;
    assign w_xfer   = w_active && !avm_waitrequest;

    always_comb begin
        w_phase_next = r_phase;
        o_done       = 1'b0;
        case (r_phase)
            PH_IDLE: begin
                if (i_req_rx)      w_phase_next = QRY_RX;
                else if (i_req_tx) w_phase_next = QRY_TX;
            end
            QRY_RX: if (w_xfer && avm_readdata[RX_OK_BIT]) w_phase_next = RD_RX;
            RD_RX: begin
                if (w_xfer) begin
                    o_done       = 1'b1;
                    w_phase_next = PH_IDLE;
                end
            end
            QRY_TX: if (w_xfer && avm_readdata[TX_OK_BIT]) w_phase_next = WR_TX;
            WR_TX: begin
                if (w_xfer) begin
                    o_done       = 1'b1;
                    w_phase_next = PH_IDLE;
                end
            end
            default: w_phase_next = PH_IDLE;
        endcase
    end

    always_comb begin
        avm_address = STATUS_BASE;
        case (r_phase)
            RD_RX:   avm_address = RX_BASE;
            WR_TX:   avm_address = TX_BASE;
            default: avm_address = STATUS_BASE;
        endcase
        avm_read  = w_active && (r_phase != WR_TX);
        avm_write = w_active && (r_phase == WR_TX);
    end

    assign avm_writedata = {24'b0, i_tx_byte};
    assign o_rx_byte     = avm_readdata[7:0];
    assign w_unused_rd   = ^avm_readdata[31:8];

endmodule

// File: rtl/rsa_uart_bridge.sv
// Avalon-MM master feeding the RSA256 core from the UART: loads key (n, d) once,
// then repeatedly receives a ciphertext block, runs the core and sends back 31 bytes.
module rsa_uart_bridge
    import rsa_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished
);

    localparam logic [6:0] KEY_LAST  = 7'(2 * BLOCK_BYTES - 1);
    localparam logic [6:0] DATA_LAST = 7'(BLOCK_BYTES - 1);
    localparam logic [6:0] SEND_LAST = 7'(OUT_BYTES - 1);
    localparam logic [6:0] N_BYTES   = 7'(BLOCK_BYTES);

    top_state_t   r_state;
    top_state_t   w_state_next;
    logic [6:0]   r_cnt;
    logic [255:0] r_n;
    logic [255:0] r_d;
    logic [255:0] r_a;
    logic [255:0] r_tx;
    logic         r_start;
    logic         w_done;
    logic [7:0]   w_rx_byte;
    logic         w_req_rx;
    logic         w_req_tx;

    assign w_req_rx = (r_state == S_GET_KEY) || (r_state == S_GET_DATA);
    assign w_req_tx = (r_state == S_SEND_DATA);

    uart_byte_port u_port (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_req_rx        (w_req_rx),
        .i_req_tx        (w_req_tx),
        .i_tx_byte       (r_tx[247:240]),
        .o_done          (w_done),
        .o_rx_byte       (w_rx_byte),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_GET_KEY;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_GET_KEY:   if (w_done && r_cnt == KEY_LAST)  w_state_next = S_GET_DATA;
            S_GET_DATA:  if (w_done && r_cnt == DATA_LAST) w_state_next = S_CALC;
            S_CALC:      if (i_core_finished)              w_state_next = S_SEND_DATA;
            S_SEND_DATA: if (w_done && r_cnt == SEND_LAST) w_state_next = S_GET_DATA;
            default:     w_state_next = S_GET_KEY;
        endcase
    end

    // Byte counter restarts on every top-state change; key bytes 0-31 fill n, 32-63 fill d.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 7'd0;
            r_n     <= '0;
            r_d     <= '0;
            r_a     <= '0;
            r_tx    <= '0;
            r_start <= 1'b0;
        end else begin
            r_start <= (r_state == S_GET_DATA) && (w_state_next == S_CALC);
            if (w_state_next != r_state) r_cnt <= 7'd0;
            else if (w_done)             r_cnt <= r_cnt + 7'd1;
            case (r_state)
                S_GET_KEY: begin
                    if (w_done) begin
                        if (r_cnt < N_BYTES) r_n <= {r_n[247:0], w_rx_byte};
                        else                 r_d <= {r_d[247:0], w_rx_byte};
                    end
                end
                S_GET_DATA:  if (w_done) r_a <= {r_a[247:0], w_rx_byte};
                S_CALC:      if (i_core_finished) r_tx <= i_core_result;
                S_SEND_DATA: if (w_done) r_tx <= r_tx << 8;
                default: ;
            endcase
        end
    end

    assign o_core_start = r_start;
    assign o_core_a     = r_a;
    assign o_core_d     = r_d;
    assign o_core_n     = r_n;

endmodule
